// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: each channel produces a divided clock
// with independent period/high time, a period-start tick and a running flag.
module clk_div_gen #(
    parameter int CH    = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       en,
    input  logic [CH*CNT_W-1:0] div,
    input  logic [CH*CNT_W-1:0] high,
    output logic [CH-1:0]       clk_out,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    logic [CH-1:0] r_clk_out;
    logic [CH-1:0] r_tick;
    logic [CH-1:0] r_running;

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign running = r_running;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CNT_W-1:0] w_div_in;
        logic [CNT_W-1:0] w_high_in;
        logic [CNT_W-1:0] w_div_eff;
        logic [CNT_W-1:0] w_high_eff;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             w_wrap;

        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div_s;
        logic [CNT_W-1:0] r_high_s;

        assign w_div_in  = div[g*CNT_W +: CNT_W];
        assign w_high_in = high[g*CNT_W +: CNT_W];
        assign w_cnt_inc = r_cnt + CNT_W'(1);
        assign w_wrap    = (r_cnt == r_div_s - CNT_W'(1));

        // Settings are clamped once, on the way into the shadow registers, so the
        // running counter never sees a degenerate period or an all-high/all-low wave.
        always_comb begin
            w_div_eff = (w_div_in < CNT_W'(2)) ? CNT_W'(2) : w_div_in;
            if (w_high_in == '0)
                w_high_eff = CNT_W'(1);
            else if (w_high_in >= w_div_eff)
                w_high_eff = w_div_eff - CNT_W'(1);
            else
                w_high_eff = w_high_in;
        end

        // NOTE: all state below uses non-blocking assignments so every flop samples
        // pre-edge values; the outputs are computed for the cycle that follows the edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state      <= IDLE;
                r_cnt        <= '0;
                r_div_s      <= CNT_W'(2);
                r_high_s     <= CNT_W'(1);
                r_clk_out[g] <= 1'b0;
                r_tick[g]    <= 1'b0;
                r_running[g] <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (en[g]) begin
                            r_state      <= RUN;
                            r_div_s      <= w_div_eff;
                            r_high_s     <= w_high_eff;
                            r_clk_out[g] <= 1'b1;
                            r_tick[g]    <= 1'b1;
                            r_running[g] <= 1'b1;
                        end else begin
                            r_clk_out[g] <= 1'b0;
                            r_tick[g]    <= 1'b0;
                            r_running[g] <= 1'b0;
                        end
                    end
                    default: begin
                        // A stop request only takes effect at a period boundary,
                        // so the last period is never shortened.
                        if (w_wrap && !en[g]) begin
                            r_state      <= IDLE;
                            r_cnt        <= '0;
                            r_clk_out[g] <= 1'b0;
                            r_tick[g]    <= 1'b0;
                            r_running[g] <= 1'b0;
                        end else begin
                            r_state      <= en[g] ? RUN : STOP;
                            r_running[g] <= 1'b1;
                            if (w_wrap) begin
                                r_cnt        <= '0;
                                r_div_s      <= w_div_eff;
                                r_high_s     <= w_high_eff;
                                r_clk_out[g] <= 1'b1;
                                r_tick[g]    <= 1'b1;
                            end else begin
                                r_cnt        <= w_cnt_inc;
                                r_clk_out[g] <= (w_cnt_inc < r_high_s);
                                r_tick[g]    <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen: waveform patterns, setting clamps,
// mid-period reprogramming, stop/restart behaviour and asynchronous reset.
module tb_clk_div_gen;

    localparam int CH    = 2;
    localparam int CNT_W = 8;

    logic                clk;
    logic                rst_n;
    logic [CH-1:0]       en;
    logic [CH*CNT_W-1:0] div;
    logic [CH*CNT_W-1:0] high;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       running;

    int n_cmp;
    int n_err;

    clk_div_gen #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div     (div),
        .high    (high),
        .clk_out (clk_out),
        .tick    (tick),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples n consecutive cycles on the falling edge, first sample in the MSB position.
    task automatic collect(input int n, output logic [15:0] c0, output logic [15:0] t0,
                           output logic [15:0] r0, output logic [15:0] c1);
        c0 = '0; t0 = '0; r0 = '0; c1 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c0 = {c0[14:0], clk_out[0]};
            t0 = {t0[14:0], tick[0]};
            r0 = {r0[14:0], running[0]};
            c1 = {c1[14:0], clk_out[1]};
        end
    endtask

    // Pulses reset and leaves the bench at a falling edge with everything disabled.
    task automatic restart();
        en    = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] c0, t0, r0, c1;
    int          ones;

    initial begin
        n_cmp = 0;
        n_err = 0;
        en    = '0;
        div   = '0;
        high  = '0;
        rst_n = 1'b0;
        #1;
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick",    32'(tick),    32'h0);
        check("reset_running", 32'(running), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'({clk_out, tick, running}), 32'h0);

        // div=4 high=2 on ch0 only
        div[7:0] = 8'd4; high[7:0] = 8'd2; en = 2'b01;
        collect(8, c0, t0, r0, c1);
        check("d4h2_clk",     32'(c0[7:0]), 32'b11001100);
        check("d4h2_tick",    32'(t0[7:0]), 32'b10001000);
        check("d4h2_running", 32'(r0[7:0]), 32'b11111111);
        check("d4h2_ch1_off", 32'(c1[7:0]), 32'b00000000);

        restart();
        div[7:0] = 8'd5; high[7:0] = 8'd2; en = 2'b01;
        collect(10, c0, t0, r0, c1);
        check("d5h2_clk",  32'(c0[9:0]), 32'b1100011000);
        check("d5h2_tick", 32'(t0[9:0]), 32'b1000010000);

        restart();
        div[7:0] = 8'd0; high[7:0] = 8'd1; en = 2'b01;
        collect(8, c0, t0, r0, c1);
        check("d0h1_clk", 32'(c0[7:0]), 32'b10101010);

        restart();
        div[7:0] = 8'd1; high[7:0] = 8'd1; en = 2'b01;
        collect(8, c0, t0, r0, c1);
        check("d1h1_clk",  32'(c0[7:0]), 32'b10101010);
        check("d1h1_tick", 32'(t0[7:0]), 32'b10101010);

        restart();
        div[7:0] = 8'd5; high[7:0] = 8'd0; en = 2'b01;
        collect(10, c0, t0, r0, c1);
        check("d5h0_clk", 32'(c0[9:0]), 32'b1000010000);

        // ch0 clamped high time alongside an independent ch1
        restart();
        div  = {8'd3, 8'd6};
        high = {8'd1, 8'd9};
        en   = 2'b11;
        collect(12, c0, t0, r0, c1);
        check("d6h9_clk",     32'(c0[11:0]), 32'b111110111110);
        check("ch1_d3h1_clk", 32'(c1[11:0]), 32'b100100100100);

        // Reprogramming mid-period takes effect at the next boundary
        restart();
        div = '0; high = '0;
        div[7:0] = 8'd4; high[7:0] = 8'd2; en = 2'b01;
        collect(2, c0, t0, r0, c1);
        check("reprog_pre_clk", 32'(c0[1:0]), 32'b11);
        div[7:0] = 8'd8; high[7:0] = 8'd5;
        collect(10, c0, t0, r0, c1);
        check("reprog_clk",  32'(c0[9:0]), 32'b0011111000);
        check("reprog_tick", 32'(t0[9:0]), 32'b0010000000);

        // en dropped at cnt==1: period completes, then the channel goes idle
        restart();
        div[7:0] = 8'd6; high[7:0] = 8'd3; en = 2'b01;
        collect(2, c0, t0, r0, c1);
        en = 2'b00;
        collect(4, c0, t0, r0, c1);
        check("stop_tail_clk",     32'(c0[3:0]), 32'b1000);
        check("stop_tail_running", 32'(r0[3:0]), 32'b1111);
        collect(3, c0, t0, r0, c1);
        check("stop_idle_clk",     32'(c0[2:0]), 32'b000);
        check("stop_idle_tick",    32'(t0[2:0]), 32'b000);
        check("stop_idle_running", 32'(r0[2:0]), 32'b000);

        // en dropped at cnt==1 and re-raised at cnt==4: no gap, no phase change
        restart();
        en = 2'b01;
        collect(2, c0, t0, r0, c1);
        en = 2'b00;
        collect(3, c0, t0, r0, c1);
        check("resume_stop_clk", 32'(c0[2:0]), 32'b100);
        en = 2'b01;
        collect(7, c0, t0, r0, c1);
        check("resume_clk",     32'(c0[6:0]), 32'b0111000);
        check("resume_tick",    32'(t0[6:0]), 32'b0100000);
        check("resume_running", 32'(r0[6:0]), 32'b1111111);

        // Asynchronous reset in the middle of a high phase
        restart();
        div[7:0] = 8'd4; high[7:0] = 8'd2; en = 2'b01;
        collect(2, c0, t0, r0, c1);
        check("pre_rst_clk", 32'(c0[1:0]), 32'b11);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'({clk_out[0], tick[0], running[0]}), 32'b000);
        @(negedge clk);
        rst_n = 1'b1;
        collect(4, c0, t0, r0, c1);
        check("post_rst_clk", 32'(c0[3:0]), 32'b1100);

        // Largest period: div=255, high request 255 clamps to 254
        restart();
        div[7:0] = 8'd255; high[7:0] = 8'd255; en = 2'b01;
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (clk_out[0]) ones++;
        end
        check("d255_high_count", 32'(ones), 32'd254);
        check("d255_last_low",   32'(clk_out[0]), 32'd0);
        @(negedge clk);
        check("d255_wrap", 32'({clk_out[0], tick[0]}), 32'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
